bounce_gen: RTL and testbench

- Synthesizable contact-bounce emulator. It is the drive end of the debounce path.
- It takes a clean target level, from a testbench, a DIP switch or a soft register, and produces a bouncy version of it on `out`.
- `out` feeds the debounce controller input on-chip, so debounce timing can be exercised without mechanical keys.
- Bounce count and glitch widths are pseudo-random, drawn from an internal LFSR, and reproducible from `SEED`.

---
 rtl/bounce_gen.sv | 149 ++++++++++++++
 tb/tb_bounce_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: turns a clean level into a pseudo-random bouncy one for exercising debounce logic.
// Optional `bypass` input (registered straight copy of level_in) is enabled with `define BOUNCE_GEN_BYPASS_EN.
module bounce_gen #(
    parameter int          WIDTH         = 1,
    parameter int          BOUNCE_MAX    = 7,
    parameter int          GLITCH_MAX    = 7,
    parameter int          STABLE_CYCLES = 64,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef BOUNCE_GEN_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic [WIDTH-1:0] level_in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int FLIP_W = (BOUNCE_MAX > 0) ? $clog2(2 * BOUNCE_MAX + 1) : 1;
    localparam int SEG_W  = (GLITCH_MAX > 0) ? $clog2(GLITCH_MAX + 1) : 1;
    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [3:0]        BMASK     = 4'(BOUNCE_MAX);
    localparam logic [3:0]        GMASK     = 4'(GLITCH_MAX);
    localparam logic [STAB_W-1:0] STAB_LOAD = STAB_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   target, target_d;
    logic [WIDTH-1:0]   old, old_d;
    logic [WIDTH-1:0]   out_d;
    logic [FLIP_W-1:0]  flips, flips_d;
    logic [SEG_W-1:0]   seg, seg_d;
    logic [STAB_W-1:0]  stable, stable_d;
    logic               done_d;
    logic [15:0]        lfsr, lfsr_d;

    logic [3:0]         n_draw;
    logic [SEG_W-1:0]   seg_draw;
    logic [FLIP_W-1:0]  flips_draw;

    // Galois form: shift right, fold the mask in when a one drops out of bit 0.
    assign lfsr_d     = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    assign n_draw     = lfsr[3:0] & BMASK;
    assign seg_draw   = SEG_W'(lfsr[7:4] & GMASK);
    assign flips_draw = FLIP_W'({1'b0, n_draw, 1'b0});

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state;
        target_d = target;
        old_d    = old;
        out_d    = out;
        flips_d  = flips;
        seg_d    = seg;
        stable_d = stable;
        done_d   = 1'b0;

        case (state)
            IDLE: begin
                if (level_in != target) begin
                    target_d = level_in;
                    old_d    = out;
                    out_d    = level_in;
                    if (n_draw == 4'd0) begin
                        state_d  = SETTLE;
                        stable_d = STAB_LOAD;
                    end else begin
                        flips_d = flips_draw;
                        seg_d   = seg_draw;
                        state_d = BOUNCE;
                    end
                end
            end
            BOUNCE: begin
                if (seg == '0) begin
                    // An even flip count guarantees the last flip lands on target.
                    out_d   = (out == target) ? old : target;
                    flips_d = flips - FLIP_W'(1);
                    seg_d   = seg_draw;
                    if (flips == FLIP_W'(1)) begin
                        state_d  = SETTLE;
                        stable_d = STAB_LOAD;
                    end
                end else begin
                    seg_d = seg - SEG_W'(1);
                end
            end
            SETTLE: begin
                if (stable == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stable_d = stable - STAB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef BOUNCE_GEN_BYPASS_EN
        if (bypass) begin
            state_d  = IDLE;
            out_d    = level_in;
            target_d = level_in;
            done_d   = 1'b0;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            target <= '0;
            old    <= '0;
            out    <= '0;
            flips  <= '0;
            seg    <= '0;
            stable <= '0;
            done   <= 1'b0;
            lfsr   <= SEED_EFF;
        end else begin
            state  <= state_d;
            target <= target_d;
            old    <= old_d;
            out    <= out_d;
            flips  <= flips_d;
            seg    <= seg_d;
            stable <= stable_d;
            done   <= done_d;
            lfsr   <= lfsr_d;
        end
    end

`ifdef BOUNCE_GEN_BYPASS_EN
    assign busy = (state != IDLE) && !bypass;
`else
    assign busy = (state != IDLE);
`endif

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: a 4-bit bouncing instance and a 1-bit clean-step instance share clock and reset.
module tb_bounce_gen;

    localparam int          A_BM  = 7;
    localparam int          A_GM  = 7;
    localparam int          A_S   = 16;
    localparam int          B_S   = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] level_a = 4'h0;
    logic       level_b = 1'b0;
    logic [3:0] out_a;
    logic       out_b, busy_a, busy_b, done_a, done_b;
`ifdef BOUNCE_GEN_BYPASS_EN
    logic       bypass = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] m_lfsr;
    logic [3:0]  cur_a = 4'h0;
    logic        cur_b = 1'b0;
    logic [5:0]  exp_q[$];

    always #5 clk = ~clk;

    bounce_gen #(.WIDTH(4), .BOUNCE_MAX(A_BM), .GLITCH_MAX(A_GM), .STABLE_CYCLES(A_S), .SEED(SEED)) dut_a (
        .clk(clk), .reset_n(reset_n),
`ifdef BOUNCE_GEN_BYPASS_EN
        .bypass(bypass),
`endif
        .level_in(level_a), .out(out_a), .busy(busy_a), .done(done_a));

    bounce_gen #(.WIDTH(1), .BOUNCE_MAX(0), .GLITCH_MAX(7), .STABLE_CYCLES(B_S), .SEED(SEED)) dut_b (
        .clk(clk), .reset_n(reset_n),
`ifdef BOUNCE_GEN_BYPASS_EN
        .bypass(bypass),
`endif
        .level_in(level_b), .out(out_b), .busy(busy_b), .done(done_b));

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Reference LFSR: both instances share seed and reset, so one copy tracks both.
    always @(posedge clk) m_lfsr <= !reset_n ? SEED : step(m_lfsr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] obs(input int which);
        return (which == 0) ? {out_a, busy_a, done_a} : {3'b000, out_b, busy_b, done_b};
    endfunction

    // Expected per-cycle {out, busy, done} from the sampling edge (k=0) through the done cycle.
    task automatic build(input logic [15:0] l0, input int bm, input int s, input logic [3:0] ov,
                         input logic [3:0] nv, output int tf, output int dd);
        logic [15:0] l;
        int n, seg, t, p;
        int flip_t[$];
        l = l0;
        n = int'(l[3:0]) & bm;
        t = 0;
        if (n > 0) begin
            seg = int'(l[7:4]) & A_GM;
            for (int f = 0; f < 2 * n; f++) begin
                for (int r = 0; r <= seg; r++) l = step(l);
                t += seg + 1;
                flip_t.push_back(t);
                seg = int'(l[7:4]) & A_GM;
            end
        end
        tf = t;
        dd = t + s;
        for (int k = 0; k <= dd; k++) begin
            p = 0;
            foreach (flip_t[i]) if (flip_t[i] <= k) p++;
            exp_q.push_back({(p % 2 == 1) ? ov : nv, k < dd, k == dd});
        end
    endtask

    task automatic set_level(input int which, input logic [3:0] v);
        if (which == 0) level_a = v;
        else level_b = v[0];
    endtask

    // mode 1: level wiggles back and restores mid-transition; mode 2: level returns to old during SETTLE and stays.
    task automatic do_trans(input int which, input logic [3:0] nv, input int mode);
        logic [3:0] ov, prev;
        logic [5:0] o, e;
        int bm, s, tf, dd, rises, done_k, busy_n;
        bit only_two;
        bm = (which == 0) ? A_BM : 0;
        s  = (which == 0) ? A_S : B_S;
        ov = (which == 0) ? cur_a : {3'b000, cur_b};
        build(m_lfsr, bm, s, ov, nv, tf, dd);
        set_level(which, nv);
        prev = ov; rises = 0; only_two = 1'b1; done_k = -1; busy_n = 0;
        for (int k = 0; k <= dd; k++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs(which);
            e = exp_q.pop_front();
            check((which == 0) ? "trace_a" : "trace_b", 32'(o), 32'(e));
            if (o[5:2] !== prev && o[5:2] === nv) rises++;
            if (o[5:2] !== ov && o[5:2] !== nv) only_two = 1'b0;
            prev = o[5:2];
            if (o[0]) done_k = k;
            if (o[1]) busy_n++;
            if (mode == 1 && k == 0) set_level(which, ov);
            if (mode == 1 && k == 2) set_level(which, nv);
            if (mode == 2 && k == tf + 1) set_level(which, ov);
        end
        check("final_out", 32'(o[5:2]), 32'(nv));
        check("rise_count_ok", 32'(rises <= bm + 1), 32'd1);
        check("only_old_or_new", 32'(only_two), 32'd1);
        if (which == 1) begin
            check("clean_done_k", 32'(done_k), 32'(B_S));
            check("clean_busy_cycles", 32'(busy_n), 32'(B_S));
        end
        if (which == 0) cur_a = nv;
        else cur_b = nv[0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({cur_a, 2'b00});
            exp_q.push_back({3'b000, cur_b, 2'b00});
            @(posedge clk);
            @(negedge clk);
            check("idle_a", 32'(obs(0)), 32'(exp_q.pop_front()));
            check("idle_b", 32'(obs(1)), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        logic [3:0] nv, keep;
        int tries;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a", 32'(obs(0)), 32'd0);
        check("rst_b", 32'(obs(1)), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Clean step both ways on the BOUNCE_MAX=0 instance.
        do_trans(1, 4'h1, 0);
        idle(3);
        do_trans(1, 4'h0, 0);
        idle(3);

        do_trans(0, 4'hA, 0);
        idle(2);
        do_trans(0, 4'h5, 1);
        idle(5);
        keep = cur_a;
        do_trans(0, 4'h3, 2);
        do_trans(0, keep, 0);
        idle(2);

        // Reset on the first cycle of a transition that really bounces.
        tries = 0;
        while (((m_lfsr[3:0] & 4'd7) == 4'd0) && tries < 64) begin
            idle(1);
            tries++;
        end
        check("found_bounce_seed", 32'(tries < 64), 32'd1);
        level_a = cur_a ^ 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy_a), 32'd1);
        reset_n = 1'b0;
        level_a = 4'h0;
        level_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_a", 32'(obs(0)), 32'd0);
        check("mid_reset_b", 32'(obs(1)), 32'd0);
        reset_n = 1'b1;
        cur_a = 4'h0;
        cur_b = 1'b0;
        idle(A_S + 8);
        do_trans(0, 4'hA, 0);
        idle(1);

        for (int i = 0; i < 100; i++) begin
            do nv = 4'($urandom_range(0, 15)); while (nv == cur_a);
            do_trans(0, nv, 0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
